// File: rtl/link_pkg.sv
// Shared definitions for the move link: receiver/transmitter state encoding
// and the default timing constants for a 65 MHz clk_in.
package link_pkg;

   localparam int DEF_CLK_PER_SAMP  = 423;
   localparam int DEF_SAMP_PER_BIT  = 16;
   localparam int DEF_PKT_LEN       = 8;
   localparam int DEF_WAITING_COUNT = 65_000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      RECOVER = 3'd5
   } link_state_e;

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: one-cycle tick_out every CLK_PER_SAMP clk_in cycles,
// held in phase reset while clear_in is high.
module rx_tick_gen
   import link_pkg::*;
#(
   parameter int CLK_PER_SAMP = DEF_CLK_PER_SAMP
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear_in,
   output logic tick_out
);

   localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_SAMP - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt      <= '0;
         tick_out <= 1'b0;
      end else if (clear_in) begin
         cnt      <= '0;
         tick_out <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt      <= '0;
         tick_out <= 1'b1;
      end else begin
         cnt      <= cnt + 1'b1;
         tick_out <= 1'b0;
      end
   end

endmodule

// File: rtl/move_rx_framer.sv
// Oversampling serial framer for incoming move bytes (start, LSB-first data, stop).
// Build option: define RX_PARITY_EN to expect one odd-parity bit after the data.
module move_rx_framer
   import link_pkg::*;
#(
   parameter int CLK_PER_SAMP  = DEF_CLK_PER_SAMP,
   parameter int SAMP_PER_BIT  = DEF_SAMP_PER_BIT,
   parameter int PKT_LEN       = DEF_PKT_LEN,
   parameter int WAITING_COUNT = DEF_WAITING_COUNT
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rx_in,
   output logic [PKT_LEN-1:0] data_out,
   output logic               ready_out,
   output logic               frame_err_out,
   output logic               parity_err_out,
   output logic               busy_out
);

   localparam int SW = (SAMP_PER_BIT > 1)  ? $clog2(SAMP_PER_BIT)  : 1;
   localparam int BW = (PKT_LEN > 1)       ? $clog2(PKT_LEN)       : 1;
   localparam int WW = (WAITING_COUNT > 1) ? $clog2(WAITING_COUNT) : 1;

   localparam logic [SW-1:0] SAMP_A    = SW'(SAMP_PER_BIT / 2 - 1);
   localparam logic [SW-1:0] SAMP_B    = SW'(SAMP_PER_BIT / 2);
   localparam logic [SW-1:0] SAMP_C    = SW'(SAMP_PER_BIT / 2 + 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(PKT_LEN - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAITING_COUNT - 1);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic odd_parity(input logic [PKT_LEN-1:0] d);
      return ~(^d);
   endfunction

   link_state_e        state;
   logic               rx_meta, rx_sync, rx_prev;
   logic               tick;
   logic [SW-1:0]      samp_cnt;
   logic [BW-1:0]      bit_cnt;
   logic [WW-1:0]      wait_cnt;
   logic               samp_a, samp_b;
   logic [PKT_LEN-1:0] shreg;
   logic               bit_mid, bit_end, bit_val;

   rx_tick_gen #(
      .CLK_PER_SAMP(CLK_PER_SAMP)
   ) u_tick (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear_in(state == IDLE),
      .tick_out(tick)
   );

   // The third vote is the live sample, so a bit is decided on the tick that takes it.
   assign bit_mid  = tick && (samp_cnt == SAMP_C);
   assign bit_end  = tick && (samp_cnt == SAMP_LAST);
   assign bit_val  = maj3(samp_a, samp_b, rx_sync);
   assign busy_out = (state != IDLE);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         samp_cnt       <= '0;
         bit_cnt        <= '0;
         wait_cnt       <= '0;
         samp_a         <= 1'b1;
         samp_b         <= 1'b1;
         shreg          <= '0;
         data_out       <= '0;
         ready_out      <= 1'b0;
         frame_err_out  <= 1'b0;
`ifdef RX_PARITY_EN
         parity_err_out <= 1'b0;
`endif
      end else begin
         ready_out      <= 1'b0;
         frame_err_out  <= 1'b0;
`ifdef RX_PARITY_EN
         parity_err_out <= 1'b0;
`endif
         if (tick) begin
            if (samp_cnt == SAMP_A) samp_a <= rx_sync;
            if (samp_cnt == SAMP_B) samp_b <= rx_sync;
            samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               samp_cnt <= '0;
               bit_cnt  <= '0;
               wait_cnt <= '0;
               if (rx_prev && !rx_sync) state <= START;
            end
            START: begin
               if (bit_mid && bit_val) state <= IDLE;
               else if (bit_end)       state <= DATA;
            end
            DATA: begin
               if (bit_mid) shreg <= {bit_val, shreg[PKT_LEN-1:1]};
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
`ifdef RX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
               if (bit_mid && (bit_val != odd_parity(shreg))) begin
                  parity_err_out <= 1'b1;
                  state          <= RECOVER;
               end else if (bit_end) begin
                  state <= STOP;
               end
            end
`endif
            // Leave at mid-stop so a start bit in the stop's second half is seen.
            STOP: begin
               if (bit_mid) begin
                  if (bit_val) begin
                     data_out  <= shreg;
                     ready_out <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     frame_err_out <= 1'b1;
                     state         <= RECOVER;
                  end
               end
            end
            RECOVER: begin
               if (!rx_sync) begin
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef RX_PARITY_EN
   assign parity_err_out = 1'b0;
`endif

endmodule
